// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StFault   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control bundle driven by the FSM output decode.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic       fault;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive memory wait cycles; flags expiry at MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TW          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);

  logic [TW-1:0] cnt_q;

  // Count while waiting; clear on completion or when no access is pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (active && !ready) begin
      cnt_q <= cnt_q + TW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // A ready in the limit cycle completes the access instead of faulting.
  assign expired = active && !ready && (cnt_q == TW'(MEM_TIMEOUT));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Optional: define MIPS_CTRL_BNE_EN to decode bne as an inverted-sense branch.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TW          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IllegalOp,
  output logic       Fault,
  output logic [3:0] State
);

  state_e state_q, state_d;
  ctrl_t  c, c_out;
  logic   wait_active, expired;

  assign wait_active = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TW         (TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .active (wait_active),
    .ready  (MemReady),
    .expired(expired)
  );

`ifdef MIPS_CTRL_BNE_EN
  logic bne_q, bne_d;

  // Remember whether the branch in flight is bne.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bne_q <= 1'b0;
    else       bne_q <= bne_d;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Next-state and per-state control decode.
  always_comb begin
    c       = '0;
    state_d = state_q;
`ifdef MIPS_CTRL_BNE_EN
    bne_d   = bne_q;
`endif
    case (state_q)
      StFetch: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
        if (MemReady) begin
          c.ir_write = 1'b1;
          c.pc_en    = 1'b1;
          state_d    = StDecode;
        end else if (expired) begin
          state_d = StFault;
        end
      end
      StDecode: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALUOP_ADD;
`ifdef MIPS_CTRL_BNE_EN
        bne_d = (Op == OP_BNE);
`endif
        case (Op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = StBranch;
`endif
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJump;
          default: begin
            c.illegal_op = 1'b1;
            state_d      = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
        if (Op == OP_LW)      state_d = StMemRd;
        else if (Op == OP_SW) state_d = StMemWr;
        else                  state_d = StFetch;
      end
      StMemRd: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        if (MemReady)     state_d = StMemWb;
        else if (expired) state_d = StFault;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        if (MemReady)     state_d = StFetch;
        else if (expired) state_d = StFault;
      end
      StExecute: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
        state_d     = StAluWb;
      end
      StAluWb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        state_d     = StFetch;
      end
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_SUB;
        c.pc_src    = PCSRC_ALUOUT;
`ifdef MIPS_CTRL_BNE_EN
        c.pc_en     = bne_q ? ~Zero : Zero;
`else
        c.pc_en     = Zero;
`endif
        state_d     = StFetch;
      end
      StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
        state_d     = StAddiWb;
      end
      StAddiWb: begin
        c.reg_write = 1'b1;
        state_d     = StFetch;
      end
      StJump: begin
        c.pc_src = PCSRC_JUMP;
        c.pc_en  = 1'b1;
        state_d  = StFetch;
      end
      StFault: begin
        c.fault = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset forces every output low, even mid-access.
  assign c_out     = reset ? '0 : c;
  assign State     = reset ? 4'd0 : state_q;
  assign MemReq    = c_out.mem_req;
  assign MemWrite  = c_out.mem_write;
  assign IorD      = c_out.iord;
  assign IRWrite   = c_out.ir_write;
  assign PCEn      = c_out.pc_en;
  assign PCSrc     = c_out.pc_src;
  assign ALUSrcA   = c_out.alu_src_a;
  assign ALUSrcB   = c_out.alu_src_b;
  assign ALUOp     = c_out.alu_op;
  assign RegWrite  = c_out.reg_write;
  assign RegDst    = c_out.reg_dst;
  assign MemtoReg  = c_out.mem_to_reg;
  assign IllegalOp = c_out.illegal_op;
  assign Fault     = c_out.fault;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: expected output vectors are queued per cycle.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemWrite, IorD, IRWrite, PCEn, ALUSrcA;
  logic       RegWrite, RegDst, MemtoReg, IllegalOp, Fault;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [3:0] State;
  logic [20:0] obs;
  logic [20:0] sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .TW(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .IllegalOp(IllegalOp),
    .Fault(Fault), .State(State)
  );

  assign obs = {State, MemReq, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                RegWrite, RegDst, MemtoReg, IllegalOp, Fault};

  function automatic logic [20:0] mk(input logic [3:0] st, input logic req, input logic wr,
      input logic iord, input logic irw, input logic pcen, input logic [1:0] pcsrc,
      input logic srca, input logic [1:0] srcb, input logic [1:0] aluop, input logic rw,
      input logic rd, input logic m2r, input logic ill, input logic flt);
    return {st, req, wr, iord, irw, pcen, pcsrc, srca, srcb, aluop, rw, rd, m2r, ill, flt};
  endfunction

  // Expected output rows, one per state, written from the control table.
  function automatic logic [20:0] f_zero();
    return mk(4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_fetch(input logic r);
    return mk(4'd0, 1, 0, 0, r, r, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_decode(input logic ill);
    return mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, ill, 0);
  endfunction
  function automatic logic [20:0] f_memadr();
    return mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_memrd();
    return mk(4'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_memwb();
    return mk(4'd4, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0);
  endfunction
  function automatic logic [20:0] f_memwr();
    return mk(4'd5, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_exec();
    return mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_aluwb();
    return mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_branch(input logic pcen);
    return mk(4'd8, 0, 0, 0, 0, pcen, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_addiex();
    return mk(4'd9, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_addiwb();
    return mk(4'd10, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_jump();
    return mk(4'd11, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] f_fault();
    return mk(4'd12, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
  endfunction

  task automatic test_reset();
    logic [20:0] e;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      MemReady = logic'(i);
      sb_q.push_back(f_zero());
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [20:0] e;
    logic [20:0] exp_a[4];
    exp_a = '{f_fetch(1'b1), f_decode(1'b0), f_exec(), f_aluwb()};
    Op = OP_RTYPE;
    for (int i = 0; i < 4; i++) begin
      MemReady = 1'b1;
      sb_q.push_back(exp_a[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL rtype[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [20:0] e;
    logic [20:0] exp_a[8];
    logic        rdy_a[8];
    exp_a = '{f_fetch(1'b1), f_decode(1'b0), f_memadr(), f_memrd(), f_memrd(), f_memrd(),
              f_memrd(), f_memwb()};
    rdy_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    Op = OP_LW;
    for (int i = 0; i < 8; i++) begin
      MemReady = rdy_a[i];
      sb_q.push_back(exp_a[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL lw[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [20:0] e;
    logic [20:0] exp_a[3];
    logic        rdy_a[3];
    exp_a = '{f_fetch(1'b1), f_decode(1'b1), f_fetch(1'b0)};
    rdy_a = '{1'b1, 1'b0, 1'b0};
    Op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      MemReady = rdy_a[i];
      sb_q.push_back(exp_a[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [20:0] e;
    logic [20:0] exp_a[6];
    logic        z_a[6];
    exp_a = '{f_fetch(1'b1), f_decode(1'b0), f_branch(1'b1),
              f_fetch(1'b1), f_decode(1'b0), f_branch(1'b0)};
    z_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    Op = OP_BEQ;
    for (int i = 0; i < 6; i++) begin
      MemReady = 1'b1;
      Zero = z_a[i];
      sb_q.push_back(exp_a[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL beq[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bne();
    logic [20:0] e;
`ifdef MIPS_CTRL_BNE_EN
    localparam int N = 6;
    logic [20:0] exp_a[N];
    logic        z_a[N];
    exp_a = '{f_fetch(1'b1), f_decode(1'b0), f_branch(1'b0),
              f_fetch(1'b1), f_decode(1'b0), f_branch(1'b1)};
    z_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    localparam int N = 2;
    logic [20:0] exp_a[N];
    logic        z_a[N];
    exp_a = '{f_fetch(1'b1), f_decode(1'b1)};
    z_a = '{1'b0, 1'b0};
`endif
    Op = OP_BNE;
    for (int i = 0; i < N; i++) begin
      MemReady = 1'b1;
      Zero = z_a[i];
      sb_q.push_back(exp_a[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL bne[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_jump();
    logic [20:0] e;
    logic [20:0] exp_a[7];
    logic [5:0]  op_a[7];
    exp_a = '{f_fetch(1'b1), f_decode(1'b0), f_addiex(), f_addiwb(),
              f_fetch(1'b1), f_decode(1'b0), f_jump()};
    op_a = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_J, OP_J, OP_J};
    for (int i = 0; i < 7; i++) begin
      MemReady = 1'b1;
      Op = op_a[i];
      sb_q.push_back(exp_a[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL addi_jump[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [20:0] e;
    // 16 wait cycles in FETCH, then FAULT must hold even if memory answers.
    for (int i = 0; i < 19; i++) begin
      MemReady = (i >= 16);
      sb_q.push_back((i < 16) ? f_fetch(1'b0) : f_fault());
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL timeout[%0d]: got %h expected %h", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [20:0] e;
    logic [20:0] exp_a[4];
    logic        rdy_a[4];
    reset = 1'b1;
    #1;
    sb_q.push_back(f_zero());
    e = sb_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_errors++;
      $display("FAIL fault_clear: got %h expected %h", obs, e);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_a = '{f_fetch(1'b1), f_decode(1'b0), f_memadr(), f_memwr()};
    rdy_a = '{1'b1, 1'b0, 1'b0, 1'b0};
    Op = OP_SW;
    for (int i = 0; i < 4; i++) begin
      MemReady = rdy_a[i];
      sb_q.push_back(exp_a[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL sw[%0d]: got %h expected %h", i, obs, e);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    // Mid-cycle reset during the store must drop the request immediately.
    reset = 1'b1;
    #1;
    sb_q.push_back(f_zero());
    e = sb_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_errors++;
      $display("FAIL reset_mid_sw: got %h expected %h", obs, e);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.push_back(f_fetch(1'b0));
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_errors++;
      $display("FAIL after_reset: got %h expected %h", obs, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_illegal();
    test_beq();
    test_bne();
    test_addi_jump();
    test_timeout();
    test_reset_mid_sw();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
